// File: rtl/seq_stream_ctrl.sv
// -----------------------------------------------------------------------------
// seq_stream_ctrl
//
// Stream controller for a bit-serial "1011" sequence detector. A stream of
// num_words_i parallel words is accepted over a valid/ready port and shifted
// MSB-first onto det_bit_o, one bit per clock, with no gaps between words.
// The controller owns the detector's synchronous active-high reset. It counts
// detector matches, records the stream bit index of the first match, and flags
// input underrun.
//
// Handshake: a word transfers on a rising clk edge where word_valid_i and
// word_ready_o are both high. word_ready_o depends only on registered state,
// never on word_valid_i, and the source must hold word_data_i stable while
// word_valid_i is high.
//
// Optional feature: define SEQ_STREAM_CTRL_ABORT_EN to add the abort_i input,
// which ends an active stream early (done pulses, underrun stays 0, counters
// keep their partial values, buffered words are dropped).
//
// Ports:
//   clk_i             clock, all logic on the rising edge
//   rst_ni            asynchronous active-low reset
//   start_i           start pulse, honoured only in IDLE
//   num_words_i       words in the stream, sampled on an accepted start
//   word_valid_i      source has a word
//   word_data_i       word, MSB shifted first
//   word_ready_o      controller accepts word_data_i this cycle
//   det_bit_o         to detector inp_bit (registered)
//   det_reset_o       to detector reset (sync, active-high)
//   det_seen_i        from detector seq_seen (one cycle behind its input)
//   abort_i           (SEQ_STREAM_CTRL_ABORT_EN only) end the stream early
//   busy_o            high in every state other than IDLE
//   done_o            one-cycle pulse at stream end
//   underrun_o        last stream ended by underrun
//   match_count_o     matches in current/last stream, saturating
//   match_found_o     at least one match in current/last stream
//   first_match_bit_o 0-based stream bit index completing the first match
//   dbg_state_o       FSM state register, for observation only
// -----------------------------------------------------------------------------
module seq_stream_ctrl #(
    parameter int WORD_W = 8,
    parameter int LEN_W  = 8,
    parameter int CNT_W  = 16,
    parameter int IDX_W  = LEN_W + $clog2(WORD_W)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic [LEN_W-1:0]  num_words_i,
    input  logic              word_valid_i,
    input  logic [WORD_W-1:0] word_data_i,
    output logic              word_ready_o,
    output logic              det_bit_o,
    output logic              det_reset_o,
    input  logic              det_seen_i,
`ifdef SEQ_STREAM_CTRL_ABORT_EN
    input  logic              abort_i,
`endif
    output logic              busy_o,
    output logic              done_o,
    output logic              underrun_o,
    output logic [CNT_W-1:0]  match_count_o,
    output logic              match_found_o,
    output logic [IDX_W-1:0]  first_match_bit_o,
    output logic [2:0]        dbg_state_o
);

    localparam int BCW = (WORD_W > 1) ? $clog2(WORD_W) : 1;
    localparam logic [BCW-1:0]   LAST_BIT = BCW'(WORD_W - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SHIFT = 3'd2,
        S_DRAIN = 3'd3,
        S_FIN   = 3'd4
    } state_e;

    state_e            state_q, state_d;
    logic [WORD_W-1:0] shreg_q, shreg_d;
    logic [BCW-1:0]    bit_cnt_q, bit_cnt_d;   // bit position inside current word
    logic [IDX_W-1:0]  idx_q, idx_d;           // bits shifted so far in the stream
    logic [LEN_W-1:0]  len_q, len_d;           // latched num_words
    logic [LEN_W-1:0]  acc_q, acc_d;           // words accepted so far
    logic [WORD_W-1:0] buf_q, buf_d;           // one-word holding buffer
    logic              buf_full_q, buf_full_d;
    logic              underrun_q, underrun_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              found_q, found_d;
    logic [IDX_W-1:0]  first_q, first_d;

    logic              word_ready;
    logic              hs;
    logic              last_bit;

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            shreg_q    <= '0;
            bit_cnt_q  <= '0;
            idx_q      <= '0;
            len_q      <= '0;
            acc_q      <= '0;
            buf_q      <= '0;
            buf_full_q <= 1'b0;
            underrun_q <= 1'b0;
            cnt_q      <= '0;
            found_q    <= 1'b0;
            first_q    <= '0;
        end else begin
            state_q    <= state_d;
            shreg_q    <= shreg_d;
            bit_cnt_q  <= bit_cnt_d;
            idx_q      <= idx_d;
            len_q      <= len_d;
            acc_q      <= acc_d;
            buf_q      <= buf_d;
            buf_full_q <= buf_full_d;
            underrun_q <= underrun_d;
            cnt_q      <= cnt_d;
            found_q    <= found_d;
            first_q    <= first_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and handshake logic
    // -------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        shreg_d    = shreg_q;
        bit_cnt_d  = bit_cnt_q;
        idx_d      = idx_q;
        len_d      = len_q;
        acc_d      = acc_q;
        buf_d      = buf_q;
        buf_full_d = buf_full_q;
        underrun_d = underrun_q;
        cnt_d      = cnt_q;
        found_d    = found_q;
        first_d    = first_q;
        word_ready = 1'b0;

        last_bit = (bit_cnt_q == LAST_BIT);

        // Ready never depends on valid; it is decided first so the handshake
        // term below is a plain AND.
        case (state_q)
            S_LOAD:  word_ready = 1'b1;
            S_SHIFT: word_ready = !buf_full_q && (acc_q < len_q);
            default: word_ready = 1'b0;
        endcase
`ifdef SEQ_STREAM_CTRL_ABORT_EN
        // Refuse words during an abort so nothing is taken only to be dropped.
        if (abort_i) begin
            word_ready = 1'b0;
        end
`endif
        hs = word_valid_i && word_ready;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    cnt_d      = '0;
                    found_d    = 1'b0;
                    first_d    = '0;
                    underrun_d = 1'b0;
                    len_d      = num_words_i;
                    idx_d      = '0;
                    acc_d      = '0;
                    bit_cnt_d  = '0;
                    buf_full_d = 1'b0;
                    state_d    = (num_words_i != '0) ? S_LOAD : S_FIN;
                end
            end

            S_LOAD: begin
                // The detector is still in reset here, so waiting costs no bits.
                if (hs) begin
                    shreg_d   = word_data_i;
                    acc_d     = acc_q + LEN_W'(1);
                    bit_cnt_d = '0;
                    state_d   = S_SHIFT;
                end
            end

            S_SHIFT: begin
                shreg_d   = shreg_q << 1;
                idx_d     = idx_q + IDX_W'(1);
                bit_cnt_d = bit_cnt_q + BCW'(1);
                if (last_bit) begin
                    bit_cnt_d = '0;
                    if ((acc_q == len_q) && !buf_full_q) begin
                        // The word just finished was the last one.
                        state_d = S_DRAIN;
                    end else if (buf_full_q) begin
                        shreg_d    = buf_q;
                        buf_full_d = 1'b0;
                    end else if (hs) begin
                        // Bypass: the word arriving now goes straight into
                        // the shifter so the next bit follows without a gap.
                        shreg_d = word_data_i;
                        acc_d   = acc_q + LEN_W'(1);
                    end else begin
                        underrun_d = 1'b1;
                        state_d    = S_FIN;
                    end
                end else if (hs) begin
                    buf_d      = word_data_i;
                    buf_full_d = 1'b1;
                    acc_d      = acc_q + LEN_W'(1);
                end
            end

            S_DRAIN: begin
                // One extra cycle to catch the detector's response to the
                // final bit, which arrives a cycle after that bit.
                state_d = S_FIN;
            end

            S_FIN: begin
                buf_full_d = 1'b0;
                shreg_d    = '0;
                state_d    = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // det_seen_i reports the bit presented one cycle earlier, so the bit
        // that completed the match is idx_q - 1.
        if (((state_q == S_SHIFT) || (state_q == S_DRAIN)) && det_seen_i) begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
            if (!found_q) begin
                found_d = 1'b1;
                first_d = idx_q - IDX_W'(1);
            end
        end

`ifdef SEQ_STREAM_CTRL_ABORT_EN
        if (abort_i && ((state_q == S_LOAD) || (state_q == S_SHIFT) ||
                        (state_q == S_DRAIN))) begin
            state_d    = S_FIN;
            underrun_d = 1'b0;
            buf_full_d = 1'b0;
        end
`endif
    end

    // -------------------------------------------------------------------------
    // Outputs, all decoded from registers
    // -------------------------------------------------------------------------
    assign word_ready_o      = word_ready;
    assign det_bit_o         = shreg_q[WORD_W-1];
    assign det_reset_o       = (state_q == S_IDLE) || (state_q == S_LOAD) ||
                               (state_q == S_FIN);
    assign busy_o            = (state_q != S_IDLE);
    assign done_o            = (state_q == S_FIN);
    assign underrun_o        = underrun_q;
    assign match_count_o     = cnt_q;
    assign match_found_o     = found_q;
    assign first_match_bit_o = first_q;
    assign dbg_state_o       = state_q;

endmodule

// File: doc/seq_stream_ctrl.md
Name: seq_stream_ctrl

Overview:
- Stream controller for the bit-serial 1011 sequence detector.
- Accepts a programmed number of parallel words over a valid/ready port and serializes them MSB-first onto the detector's single input bit, one bit per clock, with no gaps.
- Owns the detector's synchronous active-high reset.
- Counts detector matches, records the stream bit index of the first match, and flags input underrun. Sits between the word source and one detector instance.

Parameters:
- WORD_W, 8, width of each input word in bits.
- LEN_W, 8, width of num_words; a stream is 0 to 2^LEN_W-1 words.
- CNT_W, 16, width of match_count.
- IDX_W, LEN_W+$clog2(WORD_W), width of the stream bit index and first_match_bit.

Ports:
- clk  in  1  clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  pulse; starts a stream when in IDLE
- num_words  in  LEN_W  word count, sampled on accepted start
- word_valid  in  1  source has a word
- word_data  in  WORD_W  word, MSB shifted first
- word_ready  out  1  controller accepts word_data this cycle
- det_bit  out  1  to detector inp_bit
- det_reset  out  1  to detector reset (sync, active-high)
- det_seen  in  1  from detector seq_seen
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse at stream end (normal, underrun or abort)
- underrun  out  1  last stream ended by underrun; cleared on next accepted start
- match_count  out  CNT_W  matches in current/last stream, saturating at all-ones
- match_found  out  1  at least one match in current/last stream
- first_match_bit  out  IDX_W  0-based stream bit index of the bit completing the first match

Behaviour:
- Reset values (reset low, async): state=IDLE, word_ready=0, det_bit=0, det_reset=1, busy=0, done=0, underrun=0, match_count=0, match_found=0, first_match_bit=0, holding buffer empty.
- States: IDLE, LOAD, SHIFT, DRAIN, FIN.
- det_reset is decoded from the state register only: 1 in IDLE/LOAD/FIN, 0 in SHIFT/DRAIN.
- det_bit is shreg[WORD_W-1], a register.
- IDLE: start=1 with num_words!=0 → LOAD; clears match_count, match_found, first_match_bit, underrun; latches num_words; bit index=0. With num_words==0 → FIN (done pulse, counters cleared, no words taken). start is ignored outside IDLE.
- LOAD: word_ready=1. On handshake, load shreg and go to SHIFT. The detector stays in reset, so waiting here consumes no bits.
- SHIFT: each cycle det_bit presents one bit, shreg shifts left, bit index increments.
  - One-word holding buffer: word_ready=1 when the buffer is empty and words_accepted<num_words.
  - On the last bit of a word:
    - if all words were shifted → DRAIN;
    - else if the buffer is full, or a handshake occurs this same cycle (bypass) → reload shreg, continue SHIFT, no bubble;
    - else → underrun=1, go to FIN.
- DRAIN: one cycle so the detector's registered output for the final bit is sampled. Then go to FIN.
- FIN: done=1 for one cycle, then IDLE. Any unconsumed word in the holding buffer is discarded.
- Match counting: detector output lags its input by one cycle.
  - det_seen=1 in SHIFT or DRAIN → match_count+1 (hold at max).
  - On the first such event: match_found=1 and first_match_bit = bit index − 1.
  - det_seen is ignored in all other states.
- Results hold stable from FIN until the next accepted start.
- Reset asserted mid-stream returns everything to reset values immediately; the detector is held in reset via det_reset=1.

Optional Feature:
- Macro SEQ_STREAM_CTRL_ABORT_EN.
- With the macro defined: adds input abort (1 bit). abort=1 in LOAD/SHIFT/DRAIN → FIN on the next edge. done pulses, underrun=0, counters keep their values so far, buffered words are dropped. abort in IDLE/FIN has no effect.
- Without the macro: no abort port; streams end only by completion or underrun.

Test Plan:
- num_words=1, word 0xB0 (10110000) → done after 8 SHIFT + DRAIN + FIN; match_count=1, first_match_bit=3, underrun=0.
- num_words=1, word 0xB6 (10110110, overlapping) → match_count=2, first_match_bit=3; second det_seen during bit 7.
- num_words=1, word 0x0B (match on final bit) → det_seen observed in DRAIN; match_count=1, first_match_bit=7.
- num_words=2, words 0x01 then 0x60 with word_valid held high → continuous 16-bit stream, no bubble; cross-word 1011 gives match_count=1, first_match_bit=10.
- num_words=2, second word withheld until after bit 7 → underrun=1, done pulse, det_reset=1 after FIN, match_count reflects first word only.
- num_words=0 → done one cycle later, word_ready never asserted. Separately, reset pulled low mid-SHIFT → all outputs at reset values the same cycle and det_reset=1.
